lif_potential_bank: RTL and testbench

LIF_POTENTIAL_BANK -- requirements
Module: lif_potential_bank

---
 rtl/lif_potential_bank.sv | 175 +++++++++++++++++
 tb/tb_lif_potential_bank.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lif_potential_bank.sv
// Bank of N leaky integrate-and-fire membrane potentials with a winner handshake to lateral inhibition.
// Optional WAIT watchdog enabled by defining LIF_TIMEOUT_EN.
module lif_potential_bank #(
  parameter int unsigned W          = 24,
  parameter int unsigned N          = 8,
  parameter int unsigned LEAK_SHIFT = 4,
  parameter int unsigned REFRAC     = 3,
  parameter int unsigned TIMEOUT    = 64
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  input  logic [N*W-1:0] in_current,
  output logic [N*W-1:0] potentials,
  output logic           start_li,
  input  logic           valid_li,
  input  logic [N-1:0]   won_lost,
  input  logic           first_spike,
  output logic [N-1:0]   spike_out,
  output logic           step_done,
  output logic           busy,
  output logic           timeout_err
);

  localparam int unsigned RW     = 4;
  localparam logic [7:0]  TO_LIM = 8'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INTEGRATE,
    S_REQ,
    S_WAIT,
    S_UPDATE
  } state_t;

  state_t           state_q, state_d;
  logic [W-1:0]     pot_q  [N];
  logic [W-1:0]     pot_d  [N];
  logic [RW-1:0]    refr_q [N];
  logic [RW-1:0]    refr_d [N];
  logic [N*W-1:0]   cur_q, cur_d;
  logic [N-1:0]     wl_q, wl_d;
  logic             fs_q, fs_d;
  logic [7:0]       wd_q, wd_d;
  logic             start_q, start_d;
  logic [N-1:0]     spike_q, spike_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic             terr_q, terr_d;
  logic [W:0]       sum_c;
  logic             found_c;

  // State, datapath and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      for (int k = 0; k < N; k++) begin
        pot_q[k]  <= '0;
        refr_q[k] <= '0;
      end
      cur_q   <= '0;
      wl_q    <= '0;
      fs_q    <= 1'b0;
      wd_q    <= '0;
      start_q <= 1'b0;
      spike_q <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      for (int k = 0; k < N; k++) begin
        pot_q[k]  <= pot_d[k];
        refr_q[k] <= refr_d[k];
      end
      cur_q   <= cur_d;
      wl_q    <= wl_d;
      fs_q    <= fs_d;
      wd_q    <= wd_d;
      start_q <= start_d;
      spike_q <= spike_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      terr_q  <= terr_d;
    end
  end

  // Next-state and datapath updates
  always_comb begin
    state_d = state_q;
    pot_d   = pot_q;
    refr_d  = refr_q;
    cur_d   = cur_q;
    wl_d    = wl_q;
    fs_d    = fs_q;
    wd_d    = wd_q;
    spike_d = '0;
    done_d  = 1'b0;
    terr_d  = 1'b0;
    sum_c   = '0;
    found_c = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          cur_d   = in_current;
          state_d = S_INTEGRATE;
        end
      end
      S_INTEGRATE: begin
        for (int k = 0; k < N; k++) begin
          if (refr_q[k] == '0) begin
            sum_c = {1'b0, pot_q[k]} - {1'b0, (pot_q[k] >> LEAK_SHIFT)}
                  + {1'b0, cur_q[k*W +: W]};
            pot_d[k] = sum_c[W] ? '1 : sum_c[W-1:0];
          end else begin
            refr_d[k] = refr_q[k] - RW'(1);
          end
        end
        state_d = S_REQ;
      end
      S_REQ: begin
        wd_d    = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // Watchdog saturates at its limit; it only acts when the timeout is built in
        if (wd_q != TO_LIM) wd_d = wd_q + 8'd1;
        if (valid_li) begin
          wl_d    = won_lost;
          fs_d    = first_spike;
          state_d = S_UPDATE;
        end
`ifdef LIF_TIMEOUT_EN
        else if (wd_q == TO_LIM) begin
          terr_d  = 1'b1;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
`endif
      end
      S_UPDATE: begin
        // Lowest set index wins; a win clears the whole bank
        for (int k = 0; k < N; k++) begin
          if (fs_q && wl_q[k] && !found_c) begin
            found_c    = 1'b1;
            spike_d[k] = 1'b1;
            refr_d[k]  = RW'(REFRAC);
          end
        end
        if (found_c) begin
          for (int k = 0; k < N; k++) pot_d[k] = '0;
        end
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    start_d = (state_d == S_REQ);
    busy_d  = (state_d != S_IDLE);
  end

  always_comb begin
    potentials = '0;
    for (int k = 0; k < N; k++) potentials[k*W +: W] = pot_q[k];
  end

  assign start_li    = start_q;
  assign spike_out   = spike_q;
  assign step_done   = done_q;
  assign busy        = busy_q;
  assign timeout_err = terr_q;

endmodule

// File: tb/tb_lif_potential_bank.sv
// Randomized self-checking bench for lif_potential_bank against a per-step behavioural model.
module tb_lif_potential_bank;

  localparam int unsigned W = 24, N = 8, LS = 4, REFRAC = 3, TIMEOUT = 64;
  localparam longint MAXV = (longint'(1) << W) - 1;
`ifdef LIF_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic [N*W-1:0] in_current;
  logic [N*W-1:0] potentials;
  logic           start_li;
  logic           valid_li;
  logic [N-1:0]   won_lost;
  logic           first_spike;
  logic [N-1:0]   spike_out;
  logic           step_done;
  logic           busy;
  logic           timeout_err;

  lif_potential_bank #(.W(W), .N(N), .LEAK_SHIFT(LS), .REFRAC(REFRAC), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_current(in_current),
    .potentials(potentials), .start_li(start_li), .valid_li(valid_li),
    .won_lost(won_lost), .first_spike(first_spike), .spike_out(spike_out),
    .step_done(step_done), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Behavioural model: potentials, refractory counts and expected pulse outputs
  longint       mpot [N];
  int           mref [N];
  logic [W-1:0] stim_cur [N];
  bit           cmp_en = 1'b0;
  bit           exp_start, exp_done, exp_busy, exp_terr;
  logic [N-1:0] exp_spike;
  logic [N-1:0] last_spike;
  logic         last_terr;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      for (int k = 0; k < N; k++)
        check($sformatf("pot%0d", k), 64'(potentials[k*W +: W]), 64'(mpot[k]));
      check("start_li", 64'(start_li), 64'(exp_start));
      check("spike_out", 64'(spike_out), 64'(exp_spike));
      check("step_done", 64'(step_done), 64'(exp_done));
      check("busy", 64'(busy), 64'(exp_busy));
      check("timeout_err", 64'(timeout_err), 64'(exp_terr));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [N*W-1:0] pack_cur();
    logic [N*W-1:0] p;
    for (int k = 0; k < N; k++) p[k*W +: W] = stim_cur[k];
    return p;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      mpot[k] = 0;
      mref[k] = 0;
    end
    exp_start = 0; exp_done = 0; exp_busy = 0; exp_terr = 0; exp_spike = '0;
  endtask

  task automatic model_integrate();
    for (int k = 0; k < N; k++) begin
      if (mref[k] == 0) begin
        longint t = mpot[k] - (mpot[k] >> LS) + longint'(stim_cur[k]);
        mpot[k] = (t > MAXV) ? MAXV : t;
      end else begin
        mref[k]--;
      end
    end
  endtask

  task automatic model_update(input bit fs, input logic [N-1:0] wl);
    int win = -1;
    for (int k = N - 1; k >= 0; k--) if (wl[k]) win = k;
    exp_spike = '0;
    if (fs && win >= 0) begin
      exp_spike[win] = 1'b1;
      for (int k = 0; k < N; k++) mpot[k] = 0;
      mref[win] = REFRAC;
    end
  endtask

  // One full time step; nwait counts WAIT cycles including the one carrying valid_li
  task automatic run_step(input int nwait, input bit fs, input logic [N-1:0] wl, input bit noise);
    bit timed_out = 0;
    in_valid = 1'b1;
    in_current = pack_cur();
    valid_li = noise & 1'($urandom);
    first_spike = 1'b1;
    won_lost = '1;
    tick();
    exp_busy = 1;
    in_valid = noise & 1'($urandom);
    valid_li = noise & 1'($urandom);
    tick();
    model_integrate();
    exp_start = 1;
    in_valid = noise & 1'($urandom);
    valid_li = noise & 1'($urandom);
    tick();
    exp_start = 0;
    for (int i = 1; i <= nwait; i++) begin
      bit last = (i == nwait);
      valid_li = last;
      won_lost = last ? wl : N'($urandom);
      first_spike = last ? fs : 1'($urandom);
      in_valid = noise & 1'($urandom);
      tick();
      if (last) break;
      if (TO_EN && i == TIMEOUT) begin
        exp_busy = 0; exp_done = 1; exp_terr = 1;
        timed_out = 1;
        break;
      end
    end
    if (timed_out) begin
      in_valid = 1'b0;
      valid_li = 1'b0;
      last_terr = timeout_err;
      tick();
      exp_done = 0; exp_terr = 0;
      return;
    end
    valid_li = 1'b0;
    in_valid = noise & 1'($urandom);
    tick();
    model_update(fs, wl);
    exp_busy = 0;
    exp_done = 1;
    in_valid = 1'b0;
    valid_li = noise & 1'($urandom);
    last_spike = spike_out;
    last_terr = timeout_err;
    tick();
    exp_done = 0;
    exp_spike = '0;
    valid_li = 1'b0;
  endtask

  task automatic set_all(input logic [W-1:0] v);
    for (int k = 0; k < N; k++) stim_cur[k] = v;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_current = '0;
    valid_li = 1'b0;
    won_lost = '0;
    first_spike = 1'b0;
    model_reset();
    repeat (2) tick();
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_pots", 64'(|potentials), 64'd0);
    check("reset_pulses", 64'({start_li, step_done, timeout_err, spike_out}), 64'd0);
    rst = 1'b0;
    cmp_en = 1'b1;
    tick();

    // Leak and saturation
    set_all('0);
    stim_cur[0] = W'(160);
    stim_cur[1] = W'(MAXV - 1);
    run_step(2, 1'b0, '0, 1'b0);
    stim_cur[0] = W'(20);
    stim_cur[1] = W'(MAXV);
    run_step(1, 1'b0, '1, 1'b0);
    check("leak_pot0", 64'(potentials[0 +: W]), 64'd170);
    check("sat_pot1", 64'(potentials[W +: W]), 64'hFFFFFF);
    check("nospike_fs0", 64'(last_spike), 64'd0);

    // Winner and refractory
    set_all('0);
    run_step(3, 1'b1, 8'b0000_0100, 1'b0);
    check("winner_spike", 64'(last_spike), 64'h04);
    check("winner_clear", 64'(|potentials), 64'd0);
    set_all(W'(50));
    repeat (3) run_step(1, 1'b0, '0, 1'b0);
    check("refrac_held", 64'(potentials[2*W +: W]), 64'd0);
    run_step(1, 1'b0, '0, 1'b0);
    check("refrac_resume", 64'(potentials[2*W +: W]), 64'd50);

    // Multi-hot and zero winner vectors
    run_step(2, 1'b1, 8'b0110_0000, 1'b1);
    check("multihot_spike", 64'(last_spike), 64'h20);
    run_step(2, 1'b1, 8'h00, 1'b1);
    check("zero_wl_spike", 64'(last_spike), 64'd0);
    check("zero_wl_pot0", 64'(potentials[0 +: W]), 64'd50);

    // Randomized steps with stray in_valid and valid_li
    for (int s = 0; s < 150; s++) begin
      for (int k = 0; k < N; k++)
        stim_cur[k] = ($urandom_range(0, 9) == 0) ? W'($urandom) : W'($urandom_range(0, 3000));
      run_step(int'($urandom_range(1, 8)), 1'($urandom),
               ($urandom_range(0, 3) == 0) ? '0 : N'($urandom), 1'b1);
    end

    // Reset while waiting for the winner decision
    set_all(W'(7));
    in_valid = 1'b1;
    in_current = pack_cur();
    tick();
    in_valid = 1'b0;
    exp_busy = 1;
    tick();
    model_integrate();
    exp_start = 1;
    tick();
    exp_start = 0;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    #1;
    rst = 1'b1;
    model_reset();
    #1;
    check("rst_busy_now", 64'(busy), 64'd0);
    check("rst_pots_now", 64'(|potentials), 64'd0);
    tick();
    rst = 1'b0;
    valid_li = 1'b1;
    first_spike = 1'b1;
    won_lost = 8'h01;
    tick();
    valid_li = 1'b0;
    repeat (3) tick();
    check("late_valid_ignored", 64'({busy, step_done, spike_out}), 64'd0);

    // Long wait: watchdog expiry when enabled, indefinite wait otherwise
    set_all(W'(11));
    last_terr = 1'b0;
    run_step(TIMEOUT + 10, 1'b1, 8'h01, 1'b0);
    check("long_wait_terr", 64'(last_terr), 64'(TO_EN));
    last_terr = 1'b1;
    run_step(TIMEOUT, 1'b1, 8'h02, 1'b0);
    check("expiry_valid_wins", 64'(last_terr), 64'd0);
    check("expiry_valid_spike", 64'(last_spike), 64'h02);

    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
